// File: rtl/univ_shift_reg_pkg.sv
// ---------------------------------------------------------------------------
// univ_shift_reg_pkg
// Shared definitions for the universal shift register slice:
//   - MODE_* : 3-bit manual operation codes driven on mode_i
//   - state_t: frame sequencer states (ST_IDLE, ST_SHIFT)
// ---------------------------------------------------------------------------
package univ_shift_reg_pkg;

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_SHR   = 3'b001;
  localparam logic [2:0] MODE_SHL   = 3'b010;
  localparam logic [2:0] MODE_LOAD  = 3'b011;
  localparam logic [2:0] MODE_ROTR  = 3'b100;
  localparam logic [2:0] MODE_ROTL  = 3'b101;
  localparam logic [2:0] MODE_CLEAR = 3'b110;
  localparam logic [2:0] MODE_HOLD2 = 3'b111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/univ_shift_reg_frame_bit_ctr.sv
// ---------------------------------------------------------------------------
// frame_bit_ctr
// Loadable down-counter holding the number of bits still to be shifted in
// the current frame.
// Ports:
//   clk_i    in   clock, rising edge
//   rst_i    in   asynchronous active-high reset (count -> 0)
//   load     in   load load_val (has priority over en)
//   en       in   decrement by one on this clock
//   load_val in   value loaded on load
//   count    out  registered count
//   last     out  this enabled clock takes the count from 1 to 0
// ---------------------------------------------------------------------------
module frame_bit_ctr #(
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  // Combinational so the FSM can retire the frame on the same edge that
  // shifts the final bit.
  assign last = en && (count == CNT_W'(1));

  // The count saturates at zero so a stray enable never wraps it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/univ_shift_reg.sv
// ---------------------------------------------------------------------------
// univ_shift_reg
// WIDTH-bit universal shift register (shift/rotate either way, load, clear)
// with an auto-frame sequencer: a start_i pulse loads d_i and then shifts
// out all WIDTH bits, one per en_i tick, on ser_o.
// Ports:
//   clk_i       in   clock, rising edge
//   rst_i       in   asynchronous active-high reset
//   en_i        in   shift-enable tick from the divider
//   mode_i      in   manual operation (MODE_* codes)
//   serial_r_i  in   bit entering the MSB on right shifts
//   serial_l_i  in   bit entering the LSB on left shifts
//   d_i         in   parallel load data
//   start_i     in   frame request, sampled every clock
//   dir_i       in   frame direction: 0 LSB-first, 1 MSB-first
//   q_o         out  register contents
//   ser_o       out  serial bit (q[0] for dir 0, q[WIDTH-1] for dir 1)
//   busy_o      out  frame in progress
//   done_o      out  one-cycle pulse when a frame completes
//   cnt_o       out  bits still to shift in the current frame
// ---------------------------------------------------------------------------
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  localparam int              CNT_W   = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [2:0]       mode_i,
  input  logic             serial_r_i,
  input  logic             serial_l_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             start_i,
  input  logic             dir_i,
  output logic [WIDTH-1:0] q_o,
  output logic             ser_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] cnt_o
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             dir_q, dir_d;
  logic             ser_q, ser_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ctr_load, ctr_en, ctr_last;

  frame_bit_ctr #(
    .CNT_W(CNT_W)
  ) u_ctr (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load     (ctr_load),
    .en       (ctr_en),
    .load_val (CNT_W'(WIDTH)),
    .count    (cnt_o),
    .last     (ctr_last)
  );

  // All state, including the serial output bit, lives in flops so every
  // output is glitch-free for the board-level pins.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      q_q     <= RST_VAL;
      dir_q   <= 1'b0;
      ser_q   <= RST_VAL[0];
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      dir_q   <= dir_d;
      ser_q   <= ser_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and datapath. In IDLE a start request wins over everything
  // and only loads; the start clock's en_i is deliberately not a tick.
  // In SHIFT only en_i matters: mode_i, start_i and dir_i are ignored.
  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    dir_d    = dir_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    ctr_load = 1'b0;
    ctr_en   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          q_d      = d_i;
          dir_d    = dir_i;
          ctr_load = 1'b1;
          busy_d   = 1'b1;
          state_d  = ST_SHIFT;
        end else if (en_i) begin
          case (mode_i)
            MODE_SHR: begin
              q_d   = {serial_r_i, q_q[WIDTH-1:1]};
              dir_d = 1'b0;
            end
            MODE_SHL: begin
              q_d   = {q_q[WIDTH-2:0], serial_l_i};
              dir_d = 1'b1;
            end
            MODE_ROTR: begin
              q_d   = {q_q[0], q_q[WIDTH-1:1]};
              dir_d = 1'b0;
            end
            MODE_ROTL: begin
              q_d   = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
              dir_d = 1'b1;
            end
            MODE_LOAD:  q_d = d_i;
            MODE_CLEAR: q_d = '0;
            default:    q_d = q_q;
          endcase
        end
      end

      ST_SHIFT: begin
        if (en_i) begin
          ctr_en = 1'b1;
          if (dir_q) begin
            q_d = {q_q[WIDTH-2:0], serial_l_i};
          end else begin
            q_d = {serial_r_i, q_q[WIDTH-1:1]};
          end
          if (ctr_last) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
    endcase
  end

  // The serial bit is registered from the next register value so ser_o
  // presents frame bit 0 straight from the start edge.
  assign ser_d = dir_d ? q_d[WIDTH-1] : q_d[0];

  assign q_o    = q_q;
  assign ser_o  = ser_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// ---------------------------------------------------------------------------
// tb_univ_shift_reg
// Self-checking bench for univ_shift_reg (WIDTH=8, RST_VAL=0). Expected
// values are queued as stimulus is driven and popped after the clock edge
// that should produce them.
// ---------------------------------------------------------------------------
module tb_univ_shift_reg;
  import univ_shift_reg_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             en_i;
  logic [2:0]       mode_i;
  logic             serial_r_i;
  logic             serial_l_i;
  logic [WIDTH-1:0] d_i;
  logic             start_i;
  logic             dir_i;
  logic [WIDTH-1:0] q_o;
  logic             ser_o;
  logic             busy_o;
  logic             done_o;
  logic [CNT_W-1:0] cnt_o;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic             ser;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t scoreboard[$];
  int   pass_count  = 0;
  int   check_count = 0;

  univ_shift_reg #(
    .WIDTH   (WIDTH),
    .RST_VAL (8'h00)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (en_i),
    .mode_i     (mode_i),
    .serial_r_i (serial_r_i),
    .serial_l_i (serial_l_i),
    .d_i        (d_i),
    .start_i    (start_i),
    .dir_i      (dir_i),
    .q_o        (q_o),
    .ser_o      (ser_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .cnt_o      (cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i      = 1'b1;
    en_i       = 1'b0;
    mode_i     = MODE_HOLD;
    serial_r_i = 1'b0;
    serial_l_i = 1'b0;
    d_i        = '0;
    start_i    = 1'b0;
    dir_i      = 1'b0;
    #12;
    check_count += 5;
    if (q_o !== 8'h00) $display("[TB] FAIL reset_q got %h want 00", q_o); else pass_count++;
    if (ser_o !== 1'b0) $display("[TB] FAIL reset_ser got %b want 0", ser_o); else pass_count++;
    if (busy_o !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", busy_o); else pass_count++;
    if (done_o !== 1'b0) $display("[TB] FAIL reset_done got %b want 0", done_o); else pass_count++;
    if (cnt_o !== 4'd0) $display("[TB] FAIL reset_cnt got %0d want 0", cnt_o); else pass_count++;
    @(negedge clk_i);
    rst_i = 1'b0;
    step();
  endtask

  // Manual ops table: mode, d, en, serial_r, serial_l, expected q, expected ser.
  task automatic test_manual_ops();
    logic [2:0] t_mode[14] = '{MODE_LOAD, MODE_SHR, MODE_LOAD, MODE_SHL, MODE_LOAD, MODE_ROTR,
                               MODE_LOAD, MODE_ROTL, MODE_HOLD, MODE_HOLD2, MODE_CLEAR,
                               MODE_LOAD, MODE_SHR, MODE_CLEAR};
    logic [7:0] t_d[14]    = '{8'hA5, 8'h00, 8'hA5, 8'h00, 8'h81, 8'h00, 8'h81, 8'h00,
                               8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00};
    logic       t_en[14]   = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 1};
    logic       t_sr[14]   = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    logic       t_sl[14]   = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    logic [7:0] t_q[14]    = '{8'hA5, 8'hD2, 8'hA5, 8'h4A, 8'h81, 8'hC0, 8'h81, 8'h03,
                               8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h00};
    logic       t_ser[14]  = '{1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    exp_t e;
    exp_t got;
    for (int i = 0; i < 14; i++) begin
      mode_i     = t_mode[i];
      d_i        = t_d[i];
      en_i       = t_en[i];
      serial_r_i = t_sr[i];
      serial_l_i = t_sl[i];
      e.q = t_q[i]; e.ser = t_ser[i]; e.busy = 1'b0; e.done = 1'b0; e.cnt = '0;
      scoreboard.push_back(e);
      step();
      got = scoreboard.pop_front();
      check_count += 2;
      if (q_o !== got.q) $display("[TB] FAIL manual_q[%0d] got %h want %h", i, q_o, got.q);
      else pass_count++;
      if (ser_o !== got.ser) $display("[TB] FAIL manual_ser[%0d] got %b want %b", i, ser_o, got.ser);
      else pass_count++;
    end
    mode_i = MODE_HOLD;
    en_i   = 1'b0;
    serial_r_i = 1'b0;
  endtask

  // One complete frame; en_i pulses every 'period' clocks. With junk set,
  // a start request and a clear command arrive on a tick mid-frame.
  task automatic run_frame(input logic [7:0] data, input logic direction,
                           input int period, input bit junk);
    exp_t e;
    exp_t got;
    int   ticks;
    start_i = 1'b1; d_i = data; dir_i = direction; en_i = 1'b1; mode_i = MODE_HOLD;
    e.q = data; e.ser = direction ? data[7] : data[0];
    e.busy = 1'b1; e.done = 1'b0; e.cnt = 4'd8;
    scoreboard.push_back(e);
    for (int c = 0; c <= 8 * period + 1; c++) begin
      if (c > 0) begin
        en_i = (c <= 8 * period) && (c % period == 0);
        start_i = junk && (c == 2 * period);
        mode_i  = (junk && (c == 2 * period)) ? MODE_CLEAR : MODE_HOLD;
        dir_i   = ~direction;
        d_i     = 8'h5A;
        ticks   = (c >= 8 * period) ? 8 : c / period;
        e.q     = direction ? (data << ticks) : (data >> ticks);
        e.ser   = (ticks < 8) ? (direction ? data[7 - ticks] : data[ticks]) : 1'b0;
        e.busy  = (ticks < 8);
        e.done  = (c == 8 * period);
        e.cnt   = CNT_W'(8 - ticks);
        scoreboard.push_back(e);
      end
      step();
      got = scoreboard.pop_front();
      check_count += 5;
      if (q_o !== got.q) $display("[TB] FAIL frame_q[%0d] got %h want %h", c, q_o, got.q);
      else pass_count++;
      if (ser_o !== got.ser) $display("[TB] FAIL frame_ser[%0d] got %b want %b", c, ser_o, got.ser);
      else pass_count++;
      if (busy_o !== got.busy) $display("[TB] FAIL frame_busy[%0d] got %b want %b", c, busy_o, got.busy);
      else pass_count++;
      if (done_o !== got.done) $display("[TB] FAIL frame_done[%0d] got %b want %b", c, done_o, got.done);
      else pass_count++;
      if (cnt_o !== got.cnt) $display("[TB] FAIL frame_cnt[%0d] got %0d want %0d", c, cnt_o, got.cnt);
      else pass_count++;
    end
    start_i = 1'b0; en_i = 1'b0; mode_i = MODE_HOLD;
  endtask

  task automatic test_frame();
    run_frame(8'hB4, 1'b0, 1, 1'b0);
    run_frame(8'hB4, 1'b1, 1, 1'b0);
  endtask

  task automatic test_frame_slow();
    run_frame(8'hB4, 1'b0, 4, 1'b1);
  endtask

  task automatic test_reset_mid_frame();
    start_i = 1'b1; d_i = 8'hFF; dir_i = 1'b0; en_i = 1'b1;
    step();
    start_i = 1'b0;
    step();
    step();
    #2;
    rst_i = 1'b1;
    #1;
    check_count += 4;
    if (q_o !== 8'h00) $display("[TB] FAIL rst_mid_q got %h want 00", q_o); else pass_count++;
    if (busy_o !== 1'b0) $display("[TB] FAIL rst_mid_busy got %b want 0", busy_o); else pass_count++;
    if (ser_o !== 1'b0) $display("[TB] FAIL rst_mid_ser got %b want 0", ser_o); else pass_count++;
    if (cnt_o !== 4'd0) $display("[TB] FAIL rst_mid_cnt got %0d want 0", cnt_o); else pass_count++;
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check_count++;
      if (done_o !== 1'b0) $display("[TB] FAIL rst_mid_done[%0d] got %b want 0", i, done_o);
      else pass_count++;
    end
    en_i = 1'b0;
  endtask

  // Start together with en_i loads only; then a new start on the done cycle
  // is accepted immediately.
  task automatic test_back_to_back();
    exp_t e;
    exp_t got;
    start_i = 1'b1; d_i = 8'h5A; dir_i = 1'b0; en_i = 1'b1; mode_i = MODE_SHR;
    e.q = 8'h5A; e.ser = 1'b0; e.busy = 1'b1; e.done = 1'b0; e.cnt = 4'd8;
    scoreboard.push_back(e);
    for (int c = 0; c < 10; c++) begin
      if (c > 0) begin
        start_i = (c == 9);
        d_i     = 8'hC3;
        if (c < 8) begin
          e.q = 8'h5A >> c; e.ser = e.q[0]; e.busy = 1'b1; e.done = 1'b0; e.cnt = CNT_W'(8 - c);
        end else if (c == 8) begin
          e.q = 8'h00; e.ser = 1'b0; e.busy = 1'b0; e.done = 1'b1; e.cnt = 4'd0;
        end else begin
          e.q = 8'hC3; e.ser = 1'b1; e.busy = 1'b1; e.done = 1'b0; e.cnt = 4'd8;
        end
        scoreboard.push_back(e);
      end
      step();
      got = scoreboard.pop_front();
      check_count += 4;
      if (q_o !== got.q) $display("[TB] FAIL b2b_q[%0d] got %h want %h", c, q_o, got.q);
      else pass_count++;
      if (busy_o !== got.busy) $display("[TB] FAIL b2b_busy[%0d] got %b want %b", c, busy_o, got.busy);
      else pass_count++;
      if (done_o !== got.done) $display("[TB] FAIL b2b_done[%0d] got %b want %b", c, done_o, got.done);
      else pass_count++;
      if (cnt_o !== got.cnt) $display("[TB] FAIL b2b_cnt[%0d] got %0d want %0d", c, cnt_o, got.cnt);
      else pass_count++;
    end
    start_i = 1'b0; en_i = 1'b0; mode_i = MODE_HOLD;
  endtask

  initial begin
    test_reset();
    test_manual_ops();
    test_frame();
    test_frame_slow();
    test_reset_mid_frame();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
